// File: rtl/alu_issue_stage_if.sv
// Request, ALU pin and response bundle for alu_issue_stage.
// slave = issue stage view, master = sequencer/ALU side view.
interface alu_issue_stage_if #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int DEPTH     = 8
);
  localparam int RW = 2*OP_WIDTH+1;
  localparam int CW = $clog2(DEPTH)+1;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_mode;
  logic [CMD_WIDTH-1:0] req_cmd;
  logic                 req_cin;
  logic [1:0]           req_inp_valid;
  logic [OP_WIDTH-1:0]  req_opa;
  logic [OP_WIDTH-1:0]  req_opb;

  logic                 CE;
  logic                 MODE;
  logic                 CIN;
  logic [CMD_WIDTH-1:0] CMD;
  logic [1:0]           INP_VALID;
  logic [OP_WIDTH-1:0]  OPA;
  logic [OP_WIDTH-1:0]  OPB;

  logic [RW-1:0]        RES;
  logic                 ERR;
  logic                 OFLOW;
  logic                 COUT;
  logic                 G;
  logic                 L;
  logic                 E;

  logic                 rsp_valid;
  logic [RW-1:0]        rsp_res;
  logic [5:0]           rsp_flags;
  logic [CW-1:0]        fifo_count;

  modport slave (
    input  req_valid, req_mode, req_cmd, req_cin,
    input  req_inp_valid, req_opa, req_opb,
    output req_ready,
    output CE, MODE, CIN, CMD, INP_VALID, OPA, OPB,
    input  RES, ERR, OFLOW, COUT, G, L, E,
    output rsp_valid, rsp_res, rsp_flags, fifo_count
  );

  modport master (
    output req_valid, req_mode, req_cmd, req_cin,
    output req_inp_valid, req_opa, req_opb,
    input  req_ready,
    input  CE, MODE, CIN, CMD, INP_VALID, OPA, OPB,
    output RES, ERR, OFLOW, COUT, G, L, E,
    input  rsp_valid, rsp_res, rsp_flags, fifo_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: request FIFO, one-at-a-time issue, latency wait, capture.
// ALU_ISSUE_PRECHECK_EN: reject malformed requests locally with ERR.
module alu_issue_stage #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int DEPTH     = 8,
  parameter int LAT       = 1,
  parameter int MULT_LAT  = 2,
  parameter int TO_LAT    = 17
) (
  input logic              CLK,
  input logic              RST,
  alu_issue_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW+1;
  localparam int RW = 2*OP_WIDTH+1;
  localparam int NW = $clog2(TO_LAT+MULT_LAT+LAT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPT} state_e;

  typedef struct packed {
    logic                 mode;
    logic [CMD_WIDTH-1:0] cmd;
    logic                 cin;
    logic [1:0]           iv;
    logic [OP_WIDTH-1:0]  opa;
    logic [OP_WIDTH-1:0]  opb;
  } req_t;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  req_t          iss_q, iss_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [RW-1:0] rsp_res_q, rsp_res_d;
  logic [5:0]    rsp_flags_q, rsp_flags_d;

  req_t          mem_q [DEPTH];
  req_t          req_w;
  req_t          head;
  logic          ready;
  logic          push;
  logic          pop;
  logic          reject;
  logic          is_mult;
  logic [NW-1:0] lat_sel;

  assign req_w = '{
    mode: bus.req_mode,
    cmd:  bus.req_cmd,
    cin:  bus.req_cin,
    iv:   bus.req_inp_valid,
    opa:  bus.req_opa,
    opb:  bus.req_opb
  };

  assign head  = mem_q[rd_ptr_q];
  assign ready = !RST && (count_q < CW'(DEPTH));
  assign push  = bus.req_valid && ready;
  assign pop   = (state_q == IDLE) && (count_q != '0);

`ifdef ALU_ISSUE_PRECHECK_EN
  assign reject = (head.iv == 2'b00)
               || ( head.mode && (head.cmd > CMD_WIDTH'(10)))
               || (!head.mode && (head.cmd > CMD_WIDTH'(13)));
`else
  assign reject = 1'b0;
`endif

  assign is_mult = iss_q.mode
                && ((iss_q.cmd == CMD_WIDTH'(9))
                 || (iss_q.cmd == CMD_WIDTH'(10)));

  // Half-valid operands make the ALU sit out its own timeout.
  always_comb begin
    lat_sel = NW'(LAT);
    if (iss_q.iv == 2'b01 || iss_q.iv == 2'b10)
      lat_sel = NW'(TO_LAT);
    else if (is_mult)
      lat_sel = NW'(MULT_LAT);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    iss_d       = iss_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          if (reject) begin
            state_d     = CAPT;
            rsp_valid_d = 1'b1;
            rsp_res_d   = '0;
            rsp_flags_d = 6'b100000;
          end else begin
            iss_d   = head;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = lat_sel;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= NW'(1)) begin
          state_d     = CAPT;
          rsp_valid_d = 1'b1;
          rsp_res_d   = bus.RES;
          rsp_flags_d = {bus.ERR, bus.OFLOW, bus.COUT,
                         bus.G, bus.L, bus.E};
        end else begin
          cnt_d = cnt_q - NW'(1);
        end
      end
      CAPT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      iss_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      iss_q       <= iss_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem_q[wr_ptr_q] <= req_w;
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_count = count_q;
  assign bus.CE         = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.MODE       = iss_q.mode;
  assign bus.CMD        = iss_q.cmd;
  assign bus.CIN        = iss_q.cin;
  assign bus.INP_VALID  = iss_q.iv;
  assign bus.OPA        = iss_q.opa;
  assign bus.OPB        = iss_q.opb;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_res    = rsp_res_q;
  assign bus.rsp_flags  = rsp_flags_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU.
// Expected values are hand-computed per vector.
module tb_alu_issue_stage;
  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [8:0] alu_s;

  // Combinational ALU stand-in; pins hold steady through capture.
  always_comb begin
    alu_s     = '0;
    bus.RES   = '0;
    bus.ERR   = 1'b0;
    bus.OFLOW = 1'b0;
    bus.COUT  = 1'b0;
    bus.G     = 1'b0;
    bus.L     = 1'b0;
    bus.E     = 1'b0;
    if (bus.INP_VALID != 2'b11) begin
      bus.ERR = 1'b1;
    end else if (bus.MODE) begin
      case (bus.CMD)
        4'd0: begin
          alu_s    = {1'b0, bus.OPA} + {1'b0, bus.OPB};
          bus.RES  = 17'(alu_s);
          bus.COUT = alu_s[8];
        end
        4'd2: begin
          alu_s    = {1'b0, bus.OPA} + {1'b0, bus.OPB} + 9'(bus.CIN);
          bus.RES  = 17'(alu_s);
          bus.COUT = alu_s[8];
        end
        4'd9:  bus.RES = (17'(bus.OPA) + 17'd1) * (17'(bus.OPB) + 17'd1);
        4'd10: bus.RES = (17'(bus.OPA) << 1) * 17'(bus.OPB);
        default: bus.ERR = 1'b1;
      endcase
    end else begin
      case (bus.CMD)
        4'd0: bus.RES = 17'(bus.OPA & bus.OPB);
        4'd1: bus.RES = 17'(bus.OPA | bus.OPB);
        4'd2: bus.RES = 17'(bus.OPA ^ bus.OPB);
        4'd14, 4'd15: bus.ERR = 1'b1;
        default: bus.RES = '0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic m, input logic [3:0] c, input logic ci,
                      input logic [1:0] iv, input logic [7:0] a,
                      input logic [7:0] b, output bit acc,
                      output int cnt);
    @(negedge CLK);
    bus.req_valid     = 1'b1;
    bus.req_mode      = m;
    bus.req_cmd       = c;
    bus.req_cin       = ci;
    bus.req_inp_valid = iv;
    bus.req_opa       = a;
    bus.req_opb       = b;
    acc = bus.req_ready;
    cnt = int'(bus.fifo_count);
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
  endtask

  // exp_lat = 0 means the request must never be driven to the ALU.
  task automatic run_op(input string tag, input logic m, input logic [3:0] c,
                        input logic ci, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [16:0] exp_res,
                        input logic [5:0] exp_fl);
    bit acc;
    int cnt;
    int t_iss;
    int t_rsp;
    int ce_n;
    bit got;
    push(m, c, ci, iv, a, b, acc, cnt);
    check({tag, "_acc"}, 32'(acc), 32'd1);
    t_iss = -1;
    t_rsp = -1;
    ce_n  = 0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.CE && t_iss < 0) t_iss = i;
      if (bus.CE) ce_n++;
      if (bus.rsp_valid) begin
        got   = 1'b1;
        t_rsp = i;
        check({tag, "_res"}, 32'(bus.rsp_res), 32'(exp_res));
        check({tag, "_flags"}, 32'(bus.rsp_flags), 32'(exp_fl));
        if (exp_lat > 0)
          check({tag, "_opa_hold"}, 32'(bus.OPA), 32'(a));
        break;
      end
    end
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    check({tag, "_ce_cycles"}, 32'(ce_n), 32'(exp_lat));
    if (exp_lat > 0)
      check({tag, "_lat"}, 32'(t_rsp - t_iss), 32'(exp_lat));
    @(negedge CLK);
    check({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [16:0] q_res[$];
  logic [5:0]  q_fl[$];

  initial begin
    bit acc;
    int cnt;
    int n_acc;
    int cnt_refuse;
    int n_rsp;
    int stray;
    int ce_n;
    logic [7:0] a;
    logic [7:0] b;
    n_checks          = 0;
    n_fail            = 0;
    bus.req_valid     = 1'b0;
    bus.req_mode      = 1'b0;
    bus.req_cmd       = '0;
    bus.req_cin       = 1'b0;
    bus.req_inp_valid = '0;
    bus.req_opa       = '0;
    bus.req_opb       = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ce", 32'(bus.CE), 32'd0);
    check("rst_iv", 32'(bus.INP_VALID), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_res", 32'(bus.rsp_res), 32'd0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    RST = 1'b0;

    run_op("add", 1, 4'd0, 0, 2'b11, 8'h0F, 8'h01, 2, 17'h10, 6'b000000);
    run_op("add_cy", 1, 4'd0, 0, 2'b11, 8'hFF, 8'h01, 2, 17'h100, 6'b001000);
    run_op("addc", 1, 4'd2, 1, 2'b11, 8'h10, 8'h20, 2, 17'h31, 6'b000000);
    run_op("mul", 1, 4'd9, 0, 2'b11, 8'h03, 8'h04, 3, 17'd20, 6'b000000);
    run_op("mul_sh", 1, 4'd10, 0, 2'b11, 8'h05, 8'h06, 3, 17'h3C, 6'b000000);
    run_op("and", 0, 4'd0, 0, 2'b11, 8'hF0, 8'h3C, 2, 17'h30, 6'b000000);
    run_op("to_a", 1, 4'd0, 0, 2'b01, 8'h0F, 8'h01, 18, 17'h0, 6'b100000);
    run_op("to_b", 1, 4'd0, 0, 2'b10, 8'h0F, 8'h01, 18, 17'h0, 6'b100000);
`ifdef ALU_ISSUE_PRECHECK_EN
    run_op("iv00", 1, 4'd0, 0, 2'b00, 8'h0F, 8'h01, 0, 17'h0, 6'b100000);
    run_op("bad_cmd", 0, 4'd14, 0, 2'b11, 8'h12, 8'h34, 0, 17'h0, 6'b100000);
`else
    run_op("iv00", 1, 4'd0, 0, 2'b00, 8'h0F, 8'h01, 2, 17'h0, 6'b100000);
    run_op("bad_cmd", 0, 4'd14, 0, 2'b11, 8'h12, 8'h34, 2, 17'h0, 6'b100000);
`endif

    // Reset mid-WAIT with a second request still queued.
    push(1, 4'd0, 0, 2'b01, 8'h01, 8'h02, acc, cnt);
    push(1, 4'd0, 0, 2'b11, 8'h03, 8'h04, acc, cnt);
    repeat (5) @(negedge CLK);
    check("mid_ce_before", 32'(bus.CE), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_ce", 32'(bus.CE), 32'd0);
    check("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    stray = 0;
    ce_n  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid) stray++;
      if (bus.CE) ce_n++;
    end
    check("post_rst_rsp", 32'(stray), 32'd0);
    check("post_rst_ce", 32'(ce_n), 32'd0);

    // Back-to-back pushes; a long first op lets the FIFO fill.
    n_acc      = 0;
    cnt_refuse = -1;
    for (int k = 1; k <= 10; k++) begin
      a = 8'(k * 16 + 1);
      b = 8'(k);
      if (k == 1) begin
        push(1, 4'd0, 0, 2'b01, a, b, acc, cnt);
        if (acc) begin
          q_res.push_back(17'h0);
          q_fl.push_back(6'b100000);
        end
      end else begin
        push(1, 4'd0, 0, 2'b11, a, b, acc, cnt);
        if (acc) begin
          q_res.push_back(17'(a) + 17'(b));
          q_fl.push_back(6'b000000);
        end
      end
      if (acc) n_acc++;
      else if (cnt_refuse < 0) cnt_refuse = cnt;
    end
    check("fill_accepted", 32'(n_acc), 32'd9);
    check("fill_refuse_cnt", 32'(cnt_refuse), 32'd8);
    n_rsp = 0;
    for (int i = 0; i < 400 && n_rsp < 9; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid) begin
        n_rsp++;
        if (q_res.size() == 0) begin
          check("fill_extra_rsp", 32'd1, 32'd0);
        end else begin
          check("fill_res", 32'(bus.rsp_res), 32'(q_res.pop_front()));
          check("fill_flags", 32'(bus.rsp_flags), 32'(q_fl.pop_front()));
        end
      end
    end
    check("fill_rsp_count", 32'(n_rsp), 32'd9);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid) stray++;
    end
    check("fill_no_dup", 32'(stray), 32'd0);
    check("fill_drained", 32'(bus.fifo_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
